// File: rtl/hs_arb_pkg.sv
// Shared types and helpers for the Handshake_syn source-side arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 64;

  // Watchdog counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/hs_tx_arbiter.sv
// Shares one Handshake_syn source port between NUM_REQ requesters, keeping
// exactly one transfer in flight and flagging a synchronizer stuck in idle.
module hs_tx_arbiter
  import hs_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     sidle,
  output logic                     sready,
  output logic [ID_W+DATA_W-1:0]   din,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  arb_state_e          state, state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   sel_data;
  logic [CNT_W-1:0]    wd_cnt;
  logic                accept;
  logic                timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Offer a slot only when nothing is in flight and the synchronizer is idle.
  assign req_ready = (state == IDLE && sidle) ? grant : '0;
  assign accept    = |req_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      IDLE:      if (accept) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_LOW;
      WAIT_LOW: begin
        // A seen handshake takes precedence over an expiring watchdog.
        if (!sidle) begin
          state_nxt = WAIT_HIGH;
        end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_HIGH: if (sidle) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sready <= 1'b0;
      din    <= '0;
      ptr    <= ID_W'(NUM_REQ - 1);
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      sready <= accept;
      if (accept) begin
        din <= {grant_id, sel_data};
        ptr <= grant_id;
      end
      if (state == ISSUE)         wd_cnt <= '0;
      else if (state == WAIT_LOW) wd_cnt <= wd_cnt + 1'b1;
      if (timeout)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Self-checking bench for hs_tx_arbiter: transfer-level reference model,
// per-cycle compare, directed scenarios and a randomized synchronizer.
module tb_hs_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  localparam int M_AUTO  = 0;
  localparam int M_HI    = 1;
  localparam int M_LO    = 2;
  localparam int M_STUCK = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        sidle = 1'b1;
  logic        sready;
  logic [9:0]  din;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;
  int grant_log[$];

  // transfer-level model state
  bit         m_inflight = 1'b0;
  int         m_acc = 0;
  bit         m_low = 1'b0;
  int         m_last = NUM_REQ - 1;
  bit         m_err = 1'b0;
  logic [9:0] m_din = '0;
  int         cyc = 0;

  // synchronizer model state
  bit s_pend = 1'b0;
  int s_wait = 0;
  int s_low_left = 0;
  int s_low_len = 1;
  bit glitch_en = 1'b0;

  hs_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .sidle     (sidle),
    .sready    (sready),
    .din       (din),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  initial forever #5 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (last + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Reference: one transfer in flight; it ends on a low-then-high sidle
  // sequence seen from two cycles after accept, or on TIMEOUT idle cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_inflight = 1'b0;
      m_low      = 1'b0;
      m_last     = NUM_REQ - 1;
      m_err      = 1'b0;
      m_din      = '0;
    end else begin : upd
      int w;
      bit to;
      w  = rr_pick(req_valid, m_last);
      to = 1'b0;
      if (!m_inflight) begin
        if (sidle && w >= 0) begin
          m_inflight = 1'b1;
          m_acc      = cyc;
          m_low      = 1'b0;
          m_last     = w;
          m_din      = {w[1:0], req_data[w*DATA_W +: DATA_W]};
        end
      end else if (cyc >= m_acc + 2) begin
        if (!m_low) begin
          if (!sidle) m_low = 1'b1;
          else if (cyc == m_acc + 1 + TIMEOUT) begin
            to         = 1'b1;
            m_inflight = 1'b0;
          end
        end else if (sidle) begin
          m_inflight = 1'b0;
        end
      end
      if (to)           m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
  endtask

  task automatic compareCycle();
    int         w;
    logic [3:0] exp_rr;
    w      = rr_pick(req_valid, m_last);
    exp_rr = (!m_inflight && sidle && w >= 0) ? 4'(1 << w) : 4'b0000;
    checkOutput("cmp_req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
    checkOutput("cmp_sready", {31'd0, sready}, {31'd0, (m_inflight && cyc == m_acc + 1)});
    checkOutput("cmp_busy", {31'd0, busy}, {31'd0, m_inflight});
    checkOutput("cmp_din", {22'd0, din}, {22'd0, m_din});
    checkOutput("cmp_err", {31'd0, err}, {31'd0, m_err});
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready[k] && req_valid[k]) grant_log.push_back(k);
    end
  endtask

  // One cycle of stimulus; sidle comes from the synchronizer model or is forced.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                               input logic clr, input int mode);
    logic s;
    @(posedge clk);
    #1;
    s = 1'b1;
    if (mode == M_AUTO) begin
      if (s_low_left > 0) begin
        s = 1'b0;
        s_low_left--;
      end else if (s_pend) begin
        if (s_wait == 0) begin
          s_pend     = 1'b0;
          s_low_left = s_low_len - 1;
          s          = 1'b0;
        end else begin
          s_wait--;
        end
      end else begin
        s = glitch_en ? ($urandom_range(0, 9) != 0) : 1'b1;
      end
      if (sready) begin
        s_pend    = 1'b1;
        s_wait    = $urandom_range(0, 2);
        s_low_len = $urandom_range(1, 8);
      end
    end else begin
      s_pend     = 1'b0;
      s_low_left = 0;
      s          = (mode == M_LO) ? 1'b0 : 1'b1;
    end
    req_valid = v;
    req_data  = d;
    err_clr   = clr;
    sidle     = s;
    #2;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    req_valid  = '0;
    err_clr    = 1'b0;
    sidle      = 1'b1;
    s_pend     = 1'b0;
    s_low_left = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
  endtask

  initial begin
    int exp_c[5];
    int exp_d[3];
    int g;
    int mode;
    exp_c = '{0, 1, 2, 3, 0};
    exp_d = '{1, 3, 1};

    fork
      forever begin
        @(negedge clk);
        if (checking) compareCycle();
      end
    join_none

    // reset values
    resetDut();
    checking = 1'b1;
    checkOutput("rst_sready", {31'd0, sready}, 32'd0);
    checkOutput("rst_din", {22'd0, din}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);

    // single transfer with fixed synchronizer timing
    applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, M_HI);
    checkOutput("b_ready_T", {28'd0, req_ready}, 32'h1);
    checkOutput("b_sready_T", {31'd0, sready}, 32'd0);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_HI);
    checkOutput("b_sready_T1", {31'd0, sready}, 32'd1);
    checkOutput("b_din_T1", {22'd0, din}, 32'h0A5);
    checkOutput("b_busy_T1", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(4'b0000, 32'h0, 1'b0, M_LO);
    applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, M_HI);
    checkOutput("b_ready_T12", {28'd0, req_ready}, 32'h0);
    checkOutput("b_din_T12", {22'd0, din}, 32'h0A5);
    applyStimulus(4'b0001, 32'h0000_00A5, 1'b0, M_HI);
    checkOutput("b_ready_T13", {28'd0, req_ready}, 32'h1);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0000, 32'h0, 1'b0, M_AUTO);

    // all four requesters valid
    resetDut();
    grant_log.delete();
    for (int i = 0; i < 300 && grant_log.size() < 5; i++)
      applyStimulus(4'b1111, $urandom, 1'b0, M_AUTO);
    checkOutput("c_grant_count", {31'd0, grant_log.size() >= 5}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : -1;
      checkOutput($sformatf("c_grant%0d", i), g, exp_c[i]);
    end

    // sparse requesters 1 and 3
    resetDut();
    grant_log.delete();
    for (int i = 0; i < 300 && grant_log.size() < 3; i++)
      applyStimulus(4'b1010, $urandom, 1'b0, M_AUTO);
    checkOutput("d_grant_count", {31'd0, grant_log.size() >= 3}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : -1;
      checkOutput($sformatf("d_grant%0d", i), g, exp_d[i]);
    end

    // watchdog: synchronizer never leaves idle
    resetDut();
    applyStimulus(4'b0001, 32'h0000_003C, 1'b0, M_STUCK);
    checkOutput("e_ready_T", {28'd0, req_ready}, 32'h1);
    for (int i = 0; i < TIMEOUT + 1; i++) applyStimulus(4'b0000, 32'h0, 1'b0, M_STUCK);
    checkOutput("e_err_before", {31'd0, err}, 32'd0);
    checkOutput("e_busy_before", {31'd0, busy}, 32'd1);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_STUCK);
    checkOutput("e_err_set", {31'd0, err}, 32'd1);
    checkOutput("e_busy_idle", {31'd0, busy}, 32'd0);
    applyStimulus(4'b0000, 32'h0, 1'b1, M_HI);
    checkOutput("e_err_hold", {31'd0, err}, 32'd1);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_HI);
    checkOutput("e_err_clr", {31'd0, err}, 32'd0);
    applyStimulus(4'b0001, 32'h0000_003C, 1'b0, M_STUCK);
    for (int i = 0; i < TIMEOUT; i++) applyStimulus(4'b0000, 32'h0, 1'b0, M_STUCK);
    applyStimulus(4'b0000, 32'h0, 1'b1, M_STUCK);
    checkOutput("e_err_pre_coinc", {31'd0, err}, 32'd0);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_STUCK);
    checkOutput("e_err_set_wins", {31'd0, err}, 32'd1);

    // asynchronous reset while in WAIT_HIGH
    applyStimulus(4'b0100, 32'h005A_0000, 1'b0, M_HI);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_HI);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_LO);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_LO);
    checkOutput("f_busy_pre", {31'd0, busy}, 32'd1);
    checkOutput("f_din_pre", {22'd0, din}, 32'h25A);
    checkOutput("f_err_pre", {31'd0, err}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("f_sready_rst", {31'd0, sready}, 32'd0);
    checkOutput("f_busy_rst", {31'd0, busy}, 32'd0);
    checkOutput("f_din_rst", {22'd0, din}, 32'd0);
    checkOutput("f_err_rst", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    applyStimulus(4'b1111, 32'h4433_2211, 1'b0, M_HI);
    checkOutput("f_first_grant", {28'd0, req_ready}, 32'h1);

    // sidle low while idle blocks all grants
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1111, $urandom, 1'b0, M_LO);
      checkOutput("g_ready_blocked", {28'd0, req_ready}, 32'h0);
      checkOutput("g_sready_blocked", {31'd0, sready}, 32'd0);
    end
    applyStimulus(4'b1111, $urandom, 1'b0, M_HI);
    checkOutput("g_ready_open", {28'd0, req_ready}, 32'h1);
    applyStimulus(4'b0000, 32'h0, 1'b0, M_HI);
    checkOutput("g_sready_issue", {31'd0, sready}, 32'd1);

    // randomized traffic against the model
    resetDut();
    glitch_en = 1'b1;
    mode = M_AUTO;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) mode = ($urandom_range(0, 4) == 0) ? M_STUCK : M_AUTO;
      applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 39) == 0), mode);
    end
    glitch_en = 1'b0;
    for (int i = 0; i < 40; i++) applyStimulus(4'b0000, 32'h0, 1'b0, M_AUTO);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hs_tx_arbiter.md
Name: hs_tx_arbiter

Overview:
- Source-clock-domain scheduler that shares one Handshake_syn source port between NUM_REQ requesters.
- Round-robin picks one requester and drives a one-cycle sready with {id, data} on din.
- Tracks the sidle falling/rising sequence so that exactly one transfer is in flight.
- Watchdog flags a synchronizer that never leaves idle.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, payload bits per requester.
- ID_W, $clog2(NUM_REQ), requester tag bits prepended to the payload.
- TIMEOUT, 64, max cycles in WAIT_LOW before error (>= 4).

Ports:
- clk  in  1  source clock (sclk of the synchronizer).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_data  in  NUM_REQ*DATA_W  payloads; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  combinational one-hot accept; handshake completes when req_valid[i] && req_ready[i].
- sidle  in  1  from the synchronizer.
- sready  out  1  registered one-cycle issue strobe to the synchronizer.
- din  out  ID_W+DATA_W  registered {grant_id, data} to the synchronizer.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky watchdog error.
- err_clr  in  1  clears err.

Behaviour:
- Reset values: sready=0, din=0, busy=0, err=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 wins first).
- Reset is asynchronous and may assert mid-transfer. The FSM returns to IDLE and any accepted-but-unissued word is dropped.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - req_ready = one-hot rr grant when sidle=1 and |req_valid; 0 otherwise.
  - On accept: din <= {i, req_data[i]}, sready <= 1, pointer <= i, next state ISSUE.
- ISSUE (sready=1 this cycle only):
  - sready <= 0 next cycle; clear the watchdog counter; go WAIT_LOW.
- WAIT_LOW:
  - sidle=0 -> WAIT_HIGH.
  - Counter reaches TIMEOUT -> err <= 1, go IDLE.
  - sidle=1 is expected for the first cycle: sreq registers one cycle after sready.
- WAIT_HIGH:
  - sidle=1 -> IDLE. No timeout in this state.
- Latency: accept at cycle T, sready high at T+1, earliest next accept the cycle after sidle returns high.
- din is held constant from ISSUE until the next accept.
- Round-robin:
  - Winner is the first valid index scanning from pointer+1 upward, mod NUM_REQ.
  - Pointer updates only on accept.
  - A single requester held valid wins every slot.
- req_ready is never high outside IDLE, or in IDLE with sidle=0. A requester may drop valid without penalty.
- err_clr: clears err in the same cycle as it is sampled. If err_clr coincides with a new timeout, set wins.
- err has no effect on arbitration; the FSM keeps serving.

Decomposition:
- Package hs_arb_pkg holds:
  - state enum (IDLE=0, ISSUE=1, WAIT_LOW=2, WAIT_HIGH=3);
  - default TIMEOUT;
  - a function for the counter width, $clog2(TIMEOUT+1).
- One sub-module rr_arbiter (NUM_REQ): purely combinational, with inputs req, ptr and outputs grant one-hot, grant_id.
- The FSM, watchdog and din/sready registers live in the top.

Test Plan:
- Reset, then req_valid=4'b0001, data0=8'hA5, sidle=1:
  - req_ready=0001 at T; sready=1 and din={2'd0,8'hA5} at T+1;
  - sidle model drops at T+2 and rises at T+12; next accept not before T+13.
- All four valid continuously with an ideal synchronizer model: grant order 0,1,2,3,0, one sready per transfer, never two sready cycles in a row.
- req_valid=4'b1010 after grant 1: next grant is 3, then 1. A requester becoming valid during WAIT_HIGH is considered only in IDLE.
- sidle held 1 after ISSUE:
  - err rises exactly TIMEOUT cycles after entering WAIT_LOW and FSM goes to IDLE;
  - err_clr pulse clears it;
  - err_clr on the same cycle as a new timeout leaves err=1.
- rst asserted in WAIT_HIGH: sready, busy, din and err are 0 immediately (asynchronous); after release requester 0 is granted first.
- sidle=0 while in IDLE with req_valid=1111: req_ready stays 0000 and sready stays 0 until sidle=1.
